// File: rtl/bresenham_stream.sv
// Streaming Bresenham line rasteriser: accepts line commands over valid/ready and
// emits one pixel per output beat, with start-pixel skip, step watchdog and abort.
module bresenham_stream #(
    parameter int COORD_W   = 10,
    parameter int MAX_STEPS = 2048,
    parameter int CNT_W     = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clk_en,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic               skip_first,
    input  logic               abort,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               pix_last,
    output logic               busy,
    output logic               done,
    output logic               timeout
);

    typedef enum logic [1:0] {IDLE = 2'd0, SKIP = 2'd1, DRAW = 2'd2} state_t;

    localparam logic [COORD_W-1:0] C_ONE     = COORD_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_LIMIT = CNT_W'(MAX_STEPS);

    state_t                    state_reg, state_next;
    logic [COORD_W-1:0]        pix_x_reg, pix_x_next, pix_y_reg, pix_y_next;
    logic [COORD_W-1:0]        x1_reg, x1_next, y1_reg, y1_next;
    logic signed [COORD_W:0]   dx_reg, dx_next, dy_reg, dy_next;
    logic signed [COORD_W+1:0] err_reg, err_next;
    logic                      sx_neg_reg, sx_neg_next, sy_neg_reg, sy_neg_next;
    logic [CNT_W-1:0]          cnt_reg, cnt_next;
    logic                      pix_valid_reg, pix_valid_next, pix_last_reg, pix_last_next;
    logic                      done_reg, done_next, timeout_reg, timeout_next;

    logic                      accept, beat, start_is_end, hit_limit;
    logic [COORD_W-1:0]        dx_mag, dy_mag;
    logic [CNT_W-1:0]          cnt_inc;

    // Single Bresenham step from the current registered position
    logic signed [COORD_W+2:0] e2, dx_e, ndy_e;
    logic signed [COORD_W+1:0] err_step;
    logic                      move_x, move_y, last_step;
    logic [COORD_W-1:0]        x_step, y_step;

    assign accept       = (state_reg == IDLE) && cmd_valid && !abort;
    assign beat         = (state_reg == DRAW) && pix_valid_reg && pix_ready;
    assign start_is_end = (x0 == x1) && (y0 == y1);
    assign dx_mag       = (x1 >= x0) ? (x1 - x0) : (x0 - x1);
    assign dy_mag       = (y1 >= y0) ? (y1 - y0) : (y0 - y1);
    assign cnt_inc      = cnt_reg + CNT_ONE;
    assign hit_limit    = (cnt_inc == CNT_LIMIT);

    always_comb begin
        e2       = {err_reg, 1'b0};
        dx_e     = {2'b00, dx_reg};
        ndy_e    = '0 - {2'b00, dy_reg};
        move_x   = (e2 > ndy_e);
        move_y   = (e2 < dx_e);
        err_step = err_reg;
        if (move_x) err_step = err_step - {1'b0, dy_reg};
        if (move_y) err_step = err_step + {1'b0, dx_reg};
        x_step = pix_x_reg;
        y_step = pix_y_reg;
        if (move_x) x_step = sx_neg_reg ? (pix_x_reg - C_ONE) : (pix_x_reg + C_ONE);
        if (move_y) y_step = sy_neg_reg ? (pix_y_reg - C_ONE) : (pix_y_reg + C_ONE);
        last_step = (x_step == x1_reg) && (y_step == y1_reg);
    end

    // State register and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            pix_x_reg     <= '0;
            pix_y_reg     <= '0;
            x1_reg        <= '0;
            y1_reg        <= '0;
            dx_reg        <= '0;
            dy_reg        <= '0;
            err_reg       <= '0;
            sx_neg_reg    <= 1'b0;
            sy_neg_reg    <= 1'b0;
            cnt_reg       <= '0;
            pix_valid_reg <= 1'b0;
            pix_last_reg  <= 1'b0;
            done_reg      <= 1'b0;
            timeout_reg   <= 1'b0;
        end else if (clk_en) begin
            state_reg     <= state_next;
            pix_x_reg     <= pix_x_next;
            pix_y_reg     <= pix_y_next;
            x1_reg        <= x1_next;
            y1_reg        <= y1_next;
            dx_reg        <= dx_next;
            dy_reg        <= dy_next;
            err_reg       <= err_next;
            sx_neg_reg    <= sx_neg_next;
            sy_neg_reg    <= sy_neg_next;
            cnt_reg       <= cnt_next;
            pix_valid_reg <= pix_valid_next;
            pix_last_reg  <= pix_last_next;
            done_reg      <= done_next;
            timeout_reg   <= timeout_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) begin
                if (!skip_first)       state_next = DRAW;
                else if (!start_is_end) state_next = SKIP;
            end
            SKIP: state_next = abort ? IDLE : DRAW;
            DRAW: begin
                if (abort)                                 state_next = IDLE;
                else if (beat && (pix_last_reg || hit_limit)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        pix_x_next     = pix_x_reg;
        pix_y_next     = pix_y_reg;
        x1_next        = x1_reg;
        y1_next        = y1_reg;
        dx_next        = dx_reg;
        dy_next        = dy_reg;
        err_next       = err_reg;
        sx_neg_next    = sx_neg_reg;
        sy_neg_next    = sy_neg_reg;
        cnt_next       = cnt_reg;
        pix_valid_next = pix_valid_reg;
        pix_last_next  = pix_last_reg;
        done_next      = 1'b0;
        timeout_next   = 1'b0;
        case (state_reg)
            IDLE: if (accept) begin
                x1_next     = x1;
                y1_next     = y1;
                dx_next     = {1'b0, dx_mag};
                dy_next     = {1'b0, dy_mag};
                err_next    = {2'b00, dx_mag} - {2'b00, dy_mag};
                sx_neg_next = !(x0 < x1);
                sy_neg_next = !(y0 < y1);
                pix_x_next  = x0;
                pix_y_next  = y0;
                cnt_next    = '0;
                if (skip_first) begin
                    pix_valid_next = 1'b0;
                    pix_last_next  = 1'b0;
                    done_next      = start_is_end;
                end else begin
                    pix_valid_next = 1'b1;
                    pix_last_next  = start_is_end;
                end
            end
            SKIP: begin
                if (abort) begin
                    pix_valid_next = 1'b0;
                    pix_last_next  = 1'b0;
                end else begin
                    pix_x_next     = x_step;
                    pix_y_next     = y_step;
                    err_next       = err_step;
                    pix_valid_next = 1'b1;
                    pix_last_next  = last_step;
                end
            end
            DRAW: begin
                if (abort) begin
                    pix_valid_next = 1'b0;
                    pix_last_next  = 1'b0;
                end else if (beat) begin
                    cnt_next = cnt_inc;
                    if (pix_last_reg || hit_limit) begin
                        pix_valid_next = 1'b0;
                        pix_last_next  = 1'b0;
                        done_next      = 1'b1;
                        timeout_next   = !pix_last_reg;
                    end else begin
                        pix_x_next    = x_step;
                        pix_y_next    = y_step;
                        err_next      = err_step;
                        pix_last_next = last_step;
                    end
                end
            end
            default: ;
        endcase
    end

    assign cmd_ready = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign pix_valid = pix_valid_reg;
    assign pix_x     = pix_x_reg;
    assign pix_y     = pix_y_reg;
    assign pix_last  = pix_last_reg;
    assign done      = done_reg;
    assign timeout   = timeout_reg;

endmodule

// File: doc/bresenham_stream.md
Name: bresenham_stream

Overview:
Parametrised successor to the single-line Bresenham plotter. It accepts line commands through a valid/ready handshake and emits one pixel coordinate per accepted output beat, with downstream backpressure. It adds optional first-pixel suppression for seamless polylines, a step watchdog with a timeout flag, and abort. It sits between the stroke/command generator and the framebuffer write port.

Parameters:
COORD_W, 10, width of every coordinate (unsigned).
MAX_STEPS, 2048, watchdog limit on pixels emitted per line; must be at least 2**COORD_W.
CNT_W, 12, width of the step counter; must satisfy 2**CNT_W > MAX_STEPS.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
clk_en  in  1  clock enable; all non-reset state updates require clk_en=1
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command (high only in IDLE)
x0, y0  in  COORD_W each  line start point
x1, y1  in  COORD_W each  line end point
skip_first  in  1  suppress the start pixel (polyline continuation)
abort  in  1  terminate the current line
pix_valid  out  1  pix_x/pix_y hold a pixel
pix_ready  in  1  downstream accepts the pixel
pix_x, pix_y  out  COORD_W each  pixel coordinate
pix_last  out  1  pixel is the line endpoint
busy  out  1  state is not IDLE
done  out  1  one-cycle pulse when a line ends
timeout  out  1  registered with done; 1 = watchdog terminated the line

Behaviour:
- Reset (async): state=IDLE; pix_valid=0, pix_last=0, done=0, timeout=0, busy=0, cmd_ready=1, pix_x=0, pix_y=0, step counter=0.
- Every transition below occurs only on a clk edge with clk_en=1. With clk_en=0 all registers hold, including done.
- done and timeout are valid for exactly one enabled cycle. They clear on the next enabled edge.
- States: IDLE, SKIP, DRAW.
- IDLE: cmd_ready=1. Accept when cmd_valid=1. On accept:
  - latch x1/y1.
  - dx=|x1-x0| and dy=|y1-y0|, each signed COORD_W+1.
  - sx=+1 if x0<x1 else -1; sy likewise.
  - err=dx-dy, signed COORD_W+2.
  - pix_x=x0, pix_y=y0, counter=0.
- IDLE, normal accept: go to DRAW with pix_valid=1. The pixel appears in the cycle after acceptance (latency 1).
- IDLE, skip_first=1 with start==end: produce no pixel, pulse done (timeout=0), stay in IDLE.
- IDLE, skip_first=1 otherwise: go to SKIP with pix_valid=0.
- SKIP: perform one step (see step rule), set pix_valid=1, go to DRAW. First pixel appears 2 cycles after acceptance.
- DRAW: pix_x, pix_y and pix_last are stable while pix_valid=1 and pix_ready=0.
  - pix_last=1 exactly when (pix_x,pix_y)==(x1,y1).
  - On a beat (pix_valid and pix_ready), counter increments.
  - If the beat has pix_last=1: pix_valid=0, pix_last=0, done=1, timeout=0, go to IDLE.
  - Else if counter+1==MAX_STEPS: pix_valid=0, done=1, timeout=1, go to IDLE.
  - Else: step and keep pix_valid=1. Sustained throughput is 1 pixel per enabled cycle.
- Step rule: e2=2*err (signed COORD_W+3).
  - If e2>-dy: err-=dy and x+=sx.
  - If e2<dx: err+=dx and y+=sy.
  - Both tests use the pre-step e2. The err update is cumulative.
- pix_last is computed from the next coordinates so that it is registered alongside them.
- abort=1 in SKIP or DRAW: go to IDLE, pix_valid=0, pix_last=0. No done pulse. abort takes priority over a same-cycle beat. abort in IDLE is ignored, and a command presented in the same cycle is not accepted.
- Coordinates never wrap for legal inputs. Full-range lines such as 0 to 2**COORD_W-1 must not overflow dx, err or e2.
- cmd_ready=0 whenever busy=1. A new command is accepted no earlier than the enabled cycle after done.

Test Plan:
- (0,0)->(3,0), pix_ready=1 → beats (0,0),(1,0),(2,0),(3,0) on 4 consecutive cycles; pix_last on (3,0); done pulse next cycle, timeout=0.
- (5,5)->(2,1) → (5,5),(4,4),(4,3),(3,2),(2,1), last on (2,1). Repeat with pix_ready low for 3 cycles at (4,3) → coordinates held and no pixel duplicated or lost.
- (7,7)->(7,7) → single pixel with pix_last=1, then done. Same with skip_first=1 → no pix_valid, done pulse one cycle after accept.
- MAX_STEPS=4, (0,0)->(9,0) → exactly 4 pixels (0..3,0), pix_last never asserted, done=1 with timeout=1.
- (0,0)->(1023,1023), COORD_W=10 → 1024 diagonal pixels ending (1023,1023), timeout=0. clk_en toggling 50% → same sequence, and state holds on disabled cycles.
- Mid-line abort at pixel 3, and separately async reset at pixel 3 → pix_valid=0 and cmd_ready=1 (immediately on reset); no done; next command draws correctly.
